// File: rtl/instr_stream_loader.sv
// Boot loader for the RISC-V tile instruction memory.
// Takes a header word followed by N payload words from a valid/ready stream.
// Each payload word becomes four little-endian byte writes on the tile's
// configuration port. After the last word the core reset is released.
module instr_stream_loader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 24,
  parameter int unsigned MAX_WORDS  = 4096,
  parameter logic [15:0] MAGIC      = 16'hB007
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  val_in,
  output logic                  ready_upward,
  output logic                  instr_config_wr_en,
  output logic [ADDR_WIDTH-1:0] instr_config_addr,
  output logic [7:0]            instr_config_din,
  output logic                  core_resetn,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  // The word counters must also hold N itself, so they are sized for MAX_WORDS+1.
  localparam int unsigned CNT_W = $clog2(MAX_WORDS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_e;

  state_e                state_q, state_d;
  logic                  ready_q, ready_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            data_q, data_d;
  logic                  core_resetn_q, core_resetn_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [CNT_W-1:0]      widx_q, widx_d;
  logic [1:0]            bidx_q, bidx_d;

  logic                  xfer;
  logic [15:0]           hdr_cnt;
  logic                  hdr_ok;
  logic [CNT_W-1:0]      widx_nx;
  logic [7:0]            byte_sel;

  // Stream handshake, header decode and byte lane selection.
  always_comb begin
    xfer     = val_in & ready_q;
    hdr_cnt  = din[15:0];
    hdr_ok   = (din[31:16] == MAGIC) && (hdr_cnt != 16'd0) &&
               (32'(hdr_cnt) <= MAX_WORDS);
    widx_nx  = widx_q + CNT_W'(1);
    byte_sel = 8'(word_q >> {bidx_q, 3'b000});
  end

  // Next-state and registered-output logic.
  // bidx counts bytes already issued for the current word: byte 0 goes out on
  // the transfer edge, bytes 1..3 in WRITE, and bidx wrapping back to 0 marks
  // the closing cycle of the word.
  always_comb begin
    state_d       = state_q;
    ready_d       = 1'b0;
    wr_en_d       = 1'b0;
    addr_d        = addr_q;
    data_d        = data_q;
    core_resetn_d = 1'b0;
    busy_d        = 1'b0;
    done_d        = 1'b0;
    err_d         = 1'b0;
    word_d        = word_q;
    count_d       = count_q;
    widx_d        = widx_q;
    bidx_d        = bidx_q;

    case (state_q)
      S_IDLE: begin
        ready_d = 1'b1;
        if (xfer) begin
          if (hdr_ok) begin
            state_d = S_LOAD;
            count_d = CNT_W'(hdr_cnt);
            widx_d  = '0;
            busy_d  = 1'b1;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
            ready_d = 1'b0;
          end
        end
      end

      S_LOAD: begin
        ready_d = 1'b1;
        busy_d  = 1'b1;
        if (xfer) begin
          state_d = S_WRITE;
          word_d  = din;
          wr_en_d = 1'b1;
          addr_d  = ADDR_WIDTH'({widx_q, 2'd0});
          data_d  = din[7:0];
          bidx_d  = 2'd1;
          ready_d = 1'b0;
        end
      end

      S_WRITE: begin
        busy_d = 1'b1;
        if (bidx_q != 2'd0) begin
          wr_en_d = 1'b1;
          addr_d  = ADDR_WIDTH'({widx_q, bidx_q});
          data_d  = byte_sel;
          bidx_d  = bidx_q + 2'd1;
        end else begin
          widx_d = widx_nx;
          if (widx_nx < count_q) begin
            state_d = S_LOAD;
            ready_d = 1'b1;
          end else begin
            state_d       = S_DONE;
            busy_d        = 1'b0;
            done_d        = 1'b1;
            core_resetn_d = 1'b1;
          end
        end
      end

      S_DONE: begin
        done_d        = 1'b1;
        core_resetn_d = 1'b1;
      end

      S_ERR: begin
        err_d = 1'b1;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      ready_q       <= 1'b0;
      wr_en_q       <= 1'b0;
      addr_q        <= '0;
      data_q        <= '0;
      core_resetn_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      word_q        <= '0;
      count_q       <= '0;
      widx_q        <= '0;
      bidx_q        <= '0;
    end else begin
      state_q       <= state_d;
      ready_q       <= ready_d;
      wr_en_q       <= wr_en_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      core_resetn_q <= core_resetn_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
      word_q        <= word_d;
      count_q       <= count_d;
      widx_q        <= widx_d;
      bidx_q        <= bidx_d;
    end
  end

  assign ready_upward       = ready_q;
  assign instr_config_wr_en = wr_en_q;
  assign instr_config_addr  = addr_q;
  assign instr_config_din   = data_q;
  assign core_resetn        = core_resetn_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign err                = err_q;

endmodule

// File: tb/tb_instr_stream_loader.sv
// Randomised bench for instr_stream_loader with a transaction-level model.
module tb_instr_stream_loader;

  localparam int unsigned MAXW = 4096;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] din = '0;
  logic        val_in = 1'b0;
  logic        ready_upward, instr_config_wr_en;
  logic [23:0] instr_config_addr;
  logic [7:0]  instr_config_din;
  logic        core_resetn, busy, done, err;

  instr_stream_loader dut (
    .clk(clk), .resetn(resetn), .din(din), .val_in(val_in),
    .ready_upward(ready_upward), .instr_config_wr_en(instr_config_wr_en),
    .instr_config_addr(instr_config_addr), .instr_config_din(instr_config_din),
    .core_resetn(core_resetn), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          a;
    logic [7:0]  d;
  } wr_t;

  int vec = 0;
  int mis = 0;

  // Model: phase 0 = awaiting header, 1 = loading, 2 = all words taken, 3 = rejected.
  int   m_phase, m_n, m_w;
  wr_t  q[$];
  wr_t  wlog[$];
  bit   exp_done, done_next, final_pending;
  int   last_a;
  logic [7:0] last_d;
  int   strobe_cnt, cyc, last_strobe_cyc, done_cyc;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      mis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete(); wlog.delete();
    m_phase = 0; m_n = 0; m_w = 0;
    exp_done = 0; done_next = 0; final_pending = 0;
    last_a = 0; last_d = '0;
    strobe_cnt = 0; last_strobe_cyc = -1; done_cyc = -1;
  endtask

  // A word the DUT is about to accept on the next rising edge.
  task automatic model_push(input logic [31:0] w);
    wr_t e;
    if (m_phase == 0) begin
      if (w[31:16] == 16'hB007 && w[15:0] >= 16'd1 && 32'(w[15:0]) <= MAXW) begin
        m_phase = 1; m_n = int'(w[15:0]); m_w = 0;
      end else begin
        m_phase = 3;
      end
    end else if (m_phase == 1) begin
      for (int k = 0; k < 4; k++) begin
        e.a = 4 * m_w + k;
        e.d = w[8*k +: 8];
        q.push_back(e);
      end
      m_w++;
      if (m_w == m_n) begin
        m_phase = 2;
        final_pending = 1;
      end
    end
  endtask

  // Per-cycle comparison against the model, just after each rising edge.
  initial begin : monitor
    wr_t e;
    bit  popped;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (!resetn) begin
        chk("rst_ready", ready_upward, 0);
        chk("rst_wr_en", instr_config_wr_en, 0);
        chk("rst_core_resetn", core_resetn, 0);
        chk("rst_flags", {busy, done, err}, 0);
      end else begin
        if (done_next) begin exp_done = 1; done_next = 0; end
        popped = 0;
        if (instr_config_wr_en) begin
          strobe_cnt++;
          last_strobe_cyc = cyc;
          if (q.size() == 0) begin
            chk("spurious_strobe", instr_config_addr, 32'hFFFF_FFFF);
          end else begin
            e = q.pop_front();
            chk("wr_addr", instr_config_addr, e.a);
            chk("wr_data", instr_config_din, e.d);
            wlog.push_back(e);
            last_a = e.a; last_d = e.d; popped = 1;
            if (final_pending && q.size() == 0) begin
              done_next = 1; final_pending = 0;
            end
          end
        end else begin
          chk("addr_hold", instr_config_addr, last_a);
          chk("data_hold", instr_config_din, last_d);
        end
        if (done && done_cyc < 0) done_cyc = cyc;
        chk("ready", ready_upward, (m_phase <= 1) && q.size() == 0 && !popped);
        chk("busy", busy, (m_phase == 1 || m_phase == 2) && !exp_done);
        chk("done", done, exp_done);
        chk("core_resetn", core_resetn, exp_done);
        chk("err", err, m_phase == 3);
      end
    end
  end

  // Must be called at a falling edge; ends just after a rising edge.
  task automatic do_reset();
    resetn = 1'b0; val_in = 1'b0;
    model_clear();
    #1;
    chk("ar_ready", ready_upward, 0);
    chk("ar_wr_en", instr_config_wr_en, 0);
    chk("ar_addr", instr_config_addr, 0);
    chk("ar_din", instr_config_din, 0);
    chk("ar_core_resetn", core_resetn, 0);
    chk("ar_busy", busy, 0);
    chk("ar_done", done, 0);
    chk("ar_err", err, 0);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("ready_first_edge", ready_upward, 1);
  endtask

  // Offers w until the DUT takes it; with gaps, val_in is randomly dropped.
  task automatic send(input logic [31:0] w, input bit gaps);
    int  guard = 0;
    bit  fin = 0;
    bit  v;
    while (!fin) begin
      @(negedge clk);
      v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      val_in = v;
      din = v ? w : $urandom;
      if (v && ready_upward) begin
        model_push(w);
        fin = 1;
      end else if (++guard > 2000) begin
        chk("send_timeout", ready_upward, 1);
        fin = 1;
      end
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk); val_in = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic wait_done(input int bound);
    int i = 0;
    @(negedge clk); val_in = 1'b0;
    while (!done && i < bound) begin @(negedge clk); i++; end
    if (!done) chk("done_timeout", done, 1);
  endtask

  task automatic load3(input bit gaps);
    send(32'hB007_0003, gaps);
    send(32'hA0A1_A2A3, gaps);
    send(32'hB0B1_B2B3, gaps);
    send(32'hC0C1_C2C3, gaps);
    wait_done(200);
  endtask

  task automatic bad_header(input logic [31:0] h);
    @(negedge clk);
    do_reset();
    send(h, 1'b0);
    idle(10);
    chk("bad_err", err, 1);
    chk("bad_ready", ready_upward, 0);
    chk("bad_core_resetn", core_resetn, 0);
    chk("bad_strobes", strobe_cnt, 0);
  endtask

  initial begin : main
    int i;
    model_clear();
    cyc = 0;
    @(negedge clk);
    do_reset();

    // Single word.
    send(32'hB007_0001, 1'b0);
    send(32'h1122_3344, 1'b0);
    wait_done(100);
    chk("t1_n", wlog.size(), 4);
    if (wlog.size() == 4) begin
      chk("t1_a0", wlog[0].a, 0); chk("t1_d0", wlog[0].d, 8'h44);
      chk("t1_a1", wlog[1].a, 1); chk("t1_d1", wlog[1].d, 8'h33);
      chk("t1_a2", wlog[2].a, 2); chk("t1_d2", wlog[2].d, 8'h22);
      chk("t1_a3", wlog[3].a, 3); chk("t1_d3", wlog[3].d, 8'h11);
    end
    chk("t1_done_lat", done_cyc - last_strobe_cyc, 1);
    chk("t1_core_resetn", core_resetn, 1);

    // Three words, val_in held high, then with random gaps.
    for (int g = 0; g < 2; g++) begin
      do_reset();
      load3(g[0]);
      chk("t3_n", wlog.size(), 12);
      if (wlog.size() == 12) begin
        chk("t3_a4", wlog[4].a, 4);   chk("t3_d4", wlog[4].d, 8'hB3);
        chk("t3_a11", wlog[11].a, 11); chk("t3_d11", wlog[11].d, 8'hC0);
      end
    end

    // Rejected headers.
    bad_header(32'hDEAD_0004);
    bad_header(32'hB007_0000);
    bad_header(32'hB007_1001);

    // Reset in the middle of a load, then a fresh single-word load.
    @(negedge clk);
    do_reset();
    send(32'hB007_0003, 1'b0);
    send(32'h0102_0304, 1'b0);
    send(32'h0506_0708, 1'b0);
    @(negedge clk); val_in = 1'b0;
    i = 0;
    while (strobe_cnt < 6 && i < 100) begin @(negedge clk); i++; end
    chk("mid_strobes", strobe_cnt, 6);
    do_reset();
    send(32'hB007_0001, 1'b1);
    send(32'hAABB_CCDD, 1'b1);
    wait_done(100);
    chk("mid_n", wlog.size(), 4);
    if (wlog.size() == 4) begin
      chk("mid_d0", wlog[0].d, 8'hDD); chk("mid_d1", wlog[1].d, 8'hCC);
      chk("mid_d2", wlog[2].d, 8'hBB); chk("mid_d3", wlog[3].d, 8'hAA);
      chk("mid_a3", wlog[3].a, 3);
    end

    // Maximum length load with a counting payload.
    @(negedge clk);
    do_reset();
    send(32'hB007_1000, 1'b0);
    for (int w = 0; w < int'(MAXW); w++) send(32'(w), 1'b0);
    wait_done(100);
    chk("max_strobes", strobe_cnt, 16384);
    chk("max_last_addr", last_a, 16383);
    chk("max_done", done, 1);
    idle(20);
    chk("max_no_more", strobe_cnt, 16384);
    chk("max_queue_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule
